// File: rtl/mm_feeder.sv
// mm_feeder: streams operand SRAM slices into the mm act/weight FIFOs, runs the array for K*precision cycles, then waits for mm_done.
// Define FEEDER_TIMEOUT_EN to add the TIMEOUT parameter and a timeout pulse that abandons a stuck DRAIN.
module mm_feeder #(
  parameter int ACT_WIDTH = 16,
  parameter int N = 2,
  parameter int K = 2,
  parameter int W_BITS = 8
`ifdef FEEDER_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 256
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [3:0]             precision,
  output logic [$clog2(K)-1:0]   act_addr,
  input  logic [N*ACT_WIDTH-1:0] act_rdata,
  output logic [$clog2(K)-1:0]   w_addr,
  input  logic [N*W_BITS-1:0]    w_rdata,
  output logic [N*ACT_WIDTH-1:0] act_din,
  output logic                   wr_en_act,
  output logic [N-1:0]           w_din,
  output logic                   wr_en_w,
  output logic                   active,
  input  logic                   mm_done,
  output logic                   busy,
  output logic                   done,
`ifdef FEEDER_TIMEOUT_EN
  output logic                   timeout,
`endif
  output logic                   err
);
  localparam int AW = $clog2(K);
  localparam int KW = $clog2(K) + 1;
  localparam int RW = $clog2(K * W_BITS) + 1;
  typedef enum logic [2:0] {IDLE, ACT_PF, LOAD_ACT, GAP, LOAD_W, SETTLE, RUN, DRAIN} state_t;
  state_t state, nxt;
  logic [KW-1:0] k;
  logic [3:0] p, prec;
  logic [RW-1:0] rc;
  logic [N-1:0][W_BITS-1:0] shreg;
  logic ok, k_last, p_last, run_end;
  assign ok = precision != 4'd0 && int'(precision) <= W_BITS;
  assign k_last = k == KW'(K - 1);
  assign p_last = p == prec - 4'd1;
  assign run_end = rc == RW'(K * int'(prec) - 1);
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nxt;
`ifdef FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT) + 1;
  logic [TW-1:0] tc;
  always_ff @(posedge clk or negedge rst)
    if (!rst) tc <= '0;
    else tc <= state == DRAIN ? tc + 1'b1 : '0;
`endif
  // rc counts the two SETTLE cycles, then restarts from 0 to time RUN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k <= '0;
      p <= '0;
      rc <= '0;
      prec <= '0;
      shreg <= '0;
      err <= 1'b0;
    end else begin
      err <= state == IDLE && start && !ok;
      if (state == IDLE && start && ok) prec <= precision;
      k <= (state == LOAD_ACT || (state == LOAD_W && p_last)) ? (k_last ? '0 : k + 1'b1) : state == LOAD_W ? k : '0;
      p <= state == LOAD_W && !p_last ? p + 4'd1 : 4'd0;
      rc <= (state == SETTLE && rc == '0) || (state == RUN && !run_end) ? rc + 1'b1 : '0;
      if (state == LOAD_W)
        for (int r = 0; r < N; r++)
          shreg[r] <= (p == 4'd0 ? w_rdata[r*W_BITS +: W_BITS] : shreg[r]) >> 1;
    end
  end
  // SRAM addresses run one slice ahead so read data lines up with the write cycle
  always_comb begin
    nxt = state;
    act_addr = '0;
    w_addr = '0;
    act_din = '0;
    w_din = '0;
    wr_en_act = 1'b0;
    wr_en_w = 1'b0;
    active = 1'b0;
    done = 1'b0;
`ifdef FEEDER_TIMEOUT_EN
    timeout = 1'b0;
`endif
    case (state)
      IDLE: nxt = start && ok ? ACT_PF : IDLE;
      ACT_PF: nxt = LOAD_ACT;
      LOAD_ACT: begin
        wr_en_act = 1'b1;
        act_din = act_rdata;
        act_addr = k_last ? '0 : AW'(k + 1'b1);
        nxt = k_last ? GAP : LOAD_ACT;
      end
      GAP: nxt = LOAD_W;
      LOAD_W: begin
        wr_en_w = 1'b1;
        for (int r = 0; r < N; r++) w_din[r] = p == 4'd0 ? w_rdata[r*W_BITS] : shreg[r][0];
        w_addr = p_last && !k_last ? AW'(k + 1'b1) : '0;
        nxt = p_last && k_last ? SETTLE : LOAD_W;
      end
      SETTLE: nxt = rc == RW'(1) ? RUN : SETTLE;
      RUN: begin
        active = 1'b1;
        nxt = run_end ? DRAIN : RUN;
      end
      DRAIN: begin
        done = mm_done;
`ifdef FEEDER_TIMEOUT_EN
        timeout = !mm_done && tc == TW'(TIMEOUT - 1);
        nxt = mm_done || timeout ? IDLE : DRAIN;
`else
        nxt = mm_done ? IDLE : DRAIN;
`endif
      end
      default: nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mm_feeder.sv
// tb_mm_feeder: randomized bench for mm_feeder; expected FIFO streams and timing come from slice/bit-order arithmetic on SRAM models.
`timescale 1ns/1ps
module tb_mm_feeder;
  localparam int ACT_WIDTH = 16;
  localparam int N = 2;
  localparam int K = 2;
  localparam int W_BITS = 8;
  localparam int AW = $clog2(K);
  localparam int OW = 2 * AW + N * ACT_WIDTH + N + 6;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, mm_done = 1'b0;
  logic [3:0] precision = '0;
  logic [AW-1:0] act_addr, w_addr;
  logic [N*ACT_WIDTH-1:0] act_rdata = '0;
  logic [N*ACT_WIDTH-1:0] act_din;
  logic [N*W_BITS-1:0] w_rdata = '0;
  logic [N-1:0] w_din;
  logic wr_en_act, wr_en_w, active, busy, done, err;
`ifdef FEEDER_TIMEOUT_EN
  logic timeout;
`endif
  logic [OW-1:0] outs;
  logic [N*ACT_WIDTH-1:0] act_mem [K];
  logic [N*W_BITS-1:0] w_mem [K];
  logic [N*ACT_WIDTH-1:0] got_act [$];
  logic [N-1:0] got_w [$];
  logic [N-1:0] exp_w [$];
  int act_cnt, first_act, done_off, to_off, err_seen, excl_bad;
  logic busy_after;
  int tests = 0, fails = 0;

  mm_feeder #(.ACT_WIDTH(ACT_WIDTH), .N(N), .K(K), .W_BITS(W_BITS)
`ifdef FEEDER_TIMEOUT_EN
    , .TIMEOUT(16)
`endif
  ) dut (
    .clk(clk), .rst(rst), .start(start), .precision(precision),
    .act_addr(act_addr), .act_rdata(act_rdata), .w_addr(w_addr), .w_rdata(w_rdata),
    .act_din(act_din), .wr_en_act(wr_en_act), .w_din(w_din), .wr_en_w(wr_en_w),
    .active(active), .mm_done(mm_done), .busy(busy), .done(done),
`ifdef FEEDER_TIMEOUT_EN
    .timeout(timeout),
`endif
    .err(err)
  );

  assign outs = {act_addr, w_addr, act_din, wr_en_act, w_din, wr_en_w, active, busy, done, err};
  always #5 clk = ~clk;
  always @(posedge clk) begin
    act_rdata <= act_mem[act_addr];
    w_rdata <= w_mem[w_addr];
  end

  function automatic int run_entry(input int P);
    return 1 + K + 1 + K * P + 2;
  endfunction

  function automatic void fill_mem();
    for (int kk = 0; kk < K; kk++)
      for (int r = 0; r < N; r++) begin
        act_mem[kk][r*ACT_WIDTH +: ACT_WIDTH] = ACT_WIDTH'($urandom);
        w_mem[kk][r*W_BITS +: W_BITS] = W_BITS'($urandom);
      end
  endfunction

  // weight FIFO order: slice outer, bit inner, LSB first; one bit per row per write
  function automatic void build_exp(input int P);
    exp_w.delete();
    for (int kk = 0; kk < K; kk++)
      for (int pp = 0; pp < P; pp++) begin
        logic [N-1:0] b;
        for (int r = 0; r < N; r++) b[r] = w_mem[kk][r*W_BITS + pp];
        exp_w.push_back(b);
      end
  endfunction

  task automatic run_seq(input int P, input int dly, input bit pulse_run, input bit busy_start, input bit start_on_done);
    int drain;
    bit in_drain;
    got_act.delete();
    got_w.delete();
    act_cnt = 0; first_act = -1; done_off = -1; to_off = -1; err_seen = 0; excl_bad = 0; drain = 0;
    @(negedge clk); start = 1'b1; precision = 4'(P);
    @(negedge clk); start = 1'b0;
    for (int off = 0; off < 400 && done_off < 0 && to_off < 0; off++) begin
      if (off > 0) @(negedge clk);
      start = 1'b0;
      mm_done = 1'b0;
      #1;
      if (wr_en_act) got_act.push_back(act_din);
      if (wr_en_w) got_w.push_back(w_din);
      if (active) begin
        if (first_act < 0) first_act = off;
        act_cnt++;
      end
      if (int'(wr_en_act) + int'(wr_en_w) + int'(active) > 1) excl_bad++;
      if (err) err_seen++;
      in_drain = busy && first_act >= 0 && !active;
      mm_done = (in_drain && drain == dly) || (pulse_run && active && act_cnt == 2);
      if (busy_start && off == 3) begin start = 1'b1; precision = 4'd0; end
      if (start_on_done && mm_done && in_drain) start = 1'b1;
      #1;
      if (done) done_off = off;
`ifdef FEEDER_TIMEOUT_EN
      if (timeout) to_off = off;
`endif
      if (in_drain) drain++;
    end
    @(negedge clk); start = 1'b0; mm_done = 1'b0;
    #1 busy_after = busy;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); start = i[0]; precision = 4'd4; mm_done = i[1];
      #1 tests++;
      if (outs !== '0) begin fails++; $display("FAIL reset_outputs cycle %0d: got %h expected 0", i, outs); end
    end
    @(negedge clk); start = 1'b0; mm_done = 1'b0; rst = 1'b1;
    @(negedge clk); #1 tests++;
    if (outs !== '0) begin fails++; $display("FAIL idle_after_reset: got %h expected 0", outs); end
  endtask

  task automatic test_err();
    logic [3:0] bad [3];
    bad[0] = 4'd0; bad[1] = 4'd9; bad[2] = 4'd15;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); start = 1'b1; precision = bad[i];
      @(negedge clk); start = 1'b0;
      #1 tests++;
      if (err !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL err_pulse p=%0d: got err=%b busy=%b expected err=1 busy=0", bad[i], err, busy); end
      tests++;
      if ({act_addr, w_addr, wr_en_act, wr_en_w, active} !== '0) begin fails++; $display("FAIL err_no_reads p=%0d: got addr/strobes %b expected 0", bad[i], {act_addr, w_addr, wr_en_act, wr_en_w, active}); end
      @(negedge clk); #1 tests++;
      if (err !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL err_single p=%0d: got err=%b busy=%b expected 0 0", bad[i], err, busy); end
    end
  endtask

  task automatic test_directed();
    logic [7:0] row0, row1;
    act_mem[0] = {16'hBC00, 16'h3C00};
    act_mem[1] = {16'h4200, 16'h4000};
    w_mem[0] = {8'h0F, 8'h05};
    w_mem[1] = {8'h03, 8'h0A};
    row0 = 8'b1010_0101;
    row1 = 8'b0011_1111;
    run_seq(4, 0, 1'b0, 1'b0, 1'b0);
    tests++;
    if (got_act.size() != 2) begin fails++; $display("FAIL dir_act_count: got %0d expected 2", got_act.size()); end
    else begin
      tests++;
      if (got_act[0] !== 32'hBC003C00 || got_act[1] !== 32'h42004000) begin fails++; $display("FAIL dir_act_data: got %h %h expected bc003c00 42004000", got_act[0], got_act[1]); end
    end
    tests++;
    if (got_w.size() != 8) begin fails++; $display("FAIL dir_w_count: got %0d expected 8", got_w.size()); end
    for (int i = 0; i < got_w.size() && i < 8; i++) begin
      tests++;
      if (got_w[i] !== {row1[i], row0[i]}) begin fails++; $display("FAIL dir_w_bit %0d: got %b expected %b", i, got_w[i], {row1[i], row0[i]}); end
    end
    tests++;
    if (first_act !== 14 || act_cnt !== 8) begin fails++; $display("FAIL dir_active: got start %0d len %0d expected 14 8", first_act, act_cnt); end
    tests++;
    if (done_off !== 22 || busy_after !== 1'b0) begin fails++; $display("FAIL dir_done: got off %0d busy %b expected 22 0", done_off, busy_after); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      int P, dly;
      P = n == 0 ? 1 : n == 1 ? W_BITS : int'($urandom_range(1, W_BITS));
      dly = int'($urandom_range(0, 6));
      fill_mem();
      run_seq(P, dly, 1'b0, 1'b0, 1'b0);
      build_exp(P);
      tests++;
      if (got_act.size() != K) begin fails++; $display("FAIL rnd_act_count P=%0d: got %0d expected %0d", P, got_act.size(), K); end
      for (int i = 0; i < got_act.size() && i < K; i++) begin
        tests++;
        if (got_act[i] !== act_mem[i]) begin fails++; $display("FAIL rnd_act_data P=%0d k=%0d: got %h expected %h", P, i, got_act[i], act_mem[i]); end
      end
      tests++;
      if (got_w.size() != exp_w.size()) begin fails++; $display("FAIL rnd_w_count P=%0d: got %0d expected %0d", P, got_w.size(), exp_w.size()); end
      for (int i = 0; i < got_w.size() && i < exp_w.size(); i++) begin
        tests++;
        if (got_w[i] !== exp_w[i]) begin fails++; $display("FAIL rnd_w_bit P=%0d idx=%0d: got %b expected %b", P, i, got_w[i], exp_w[i]); end
      end
      tests++;
      if (first_act !== run_entry(P) || act_cnt !== K * P) begin fails++; $display("FAIL rnd_active P=%0d: got start %0d len %0d expected %0d %0d", P, first_act, act_cnt, run_entry(P), K * P); end
      tests++;
      if (done_off !== run_entry(P) + K * P + dly) begin fails++; $display("FAIL rnd_done P=%0d: got %0d expected %0d", P, done_off, run_entry(P) + K * P + dly); end
      tests++;
      if (excl_bad !== 0 || busy_after !== 1'b0) begin fails++; $display("FAIL rnd_excl_idle P=%0d: got overlaps %0d busy %b expected 0 0", P, excl_bad, busy_after); end
    end
  endtask

  task automatic test_mm_done_order();
    fill_mem();
    run_seq(4, 5, 1'b1, 1'b0, 1'b0);
    tests++;
    if (done_off !== run_entry(4) + K * 4 + 5) begin fails++; $display("FAIL done_order: got %0d expected %0d", done_off, run_entry(4) + K * 4 + 5); end
    tests++;
    if (act_cnt !== K * 4) begin fails++; $display("FAIL done_order_active: got %0d expected %0d", act_cnt, K * 4); end
  endtask

  task automatic test_back_to_back();
    int P;
    P = int'($urandom_range(1, W_BITS));
    fill_mem();
    run_seq(P, 2, 1'b0, 1'b1, 1'b1);
    tests++;
    if (err_seen !== 0) begin fails++; $display("FAIL busy_start_err: got %0d err pulses expected 0", err_seen); end
    tests++;
    if (done_off !== run_entry(P) + K * P + 2 || act_cnt !== K * P) begin fails++; $display("FAIL busy_start_run: got done %0d len %0d expected %0d %0d", done_off, act_cnt, run_entry(P) + K * P + 2, K * P); end
    tests++;
    if (busy_after !== 1'b0) begin fails++; $display("FAIL start_on_done: got busy %b expected 0", busy_after); end
  endtask

  task automatic test_reset_mid();
    int P;
    fill_mem();
    @(negedge clk); start = 1'b1; precision = 4'd4;
    @(negedge clk); start = 1'b0;
    repeat (K + 4) @(negedge clk);
    #1 tests++;
    if (wr_en_w !== 1'b1) begin fails++; $display("FAIL mid_in_load_w: got wr_en_w %b expected 1", wr_en_w); end
    rst = 1'b0;
    #1 tests++;
    if (outs !== '0) begin fails++; $display("FAIL mid_reset_outputs: got %h expected 0", outs); end
    @(negedge clk); rst = 1'b1;
    P = int'($urandom_range(1, W_BITS));
    fill_mem();
    run_seq(P, 1, 1'b0, 1'b0, 1'b0);
    build_exp(P);
    tests++;
    if (got_act.size() != K || got_act[0] !== act_mem[0]) begin fails++; $display("FAIL mid_rerun_act: got count %0d expected %0d", got_act.size(), K); end
    tests++;
    if (got_w != exp_w) begin fails++; $display("FAIL mid_rerun_w: got count %0d expected %0d", got_w.size(), exp_w.size()); end
    tests++;
    if (first_act !== run_entry(P) || done_off !== run_entry(P) + K * P + 1) begin fails++; $display("FAIL mid_rerun_timing: got %0d %0d expected %0d %0d", first_act, done_off, run_entry(P), run_entry(P) + K * P + 1); end
  endtask

`ifdef FEEDER_TIMEOUT_EN
  task automatic test_timeout();
    fill_mem();
    run_seq(2, 100000, 1'b0, 1'b0, 1'b0);
    tests++;
    if (to_off !== run_entry(2) + K * 2 + 15 || done_off !== -1) begin fails++; $display("FAIL timeout: got to %0d done %0d expected %0d -1", to_off, done_off, run_entry(2) + K * 2 + 15); end
    tests++;
    if (busy_after !== 1'b0) begin fails++; $display("FAIL timeout_idle: got busy %b expected 0", busy_after); end
  endtask
`endif

  initial begin
    test_reset();
    test_err();
    test_directed();
    test_random();
    test_mm_done_order();
    test_back_to_back();
    test_reset_mid();
`ifdef FEEDER_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
